collision_pair_scheduler: RTL

COLLISION_PAIR_SCHEDULER -- requirements
Module: collision_pair_scheduler

---
 rtl/collision_pair_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/collision_pair_scheduler.sv
// collision_pair_scheduler: walks every ball pair (i<j), flags contacts and hands them
// to an external velocity unit, writing back both balls. Optional macro: CALC_TIMEOUT_EN.
module collision_pair_scheduler #(
  parameter int WIDTH = 32,
  parameter int FRAC_WIDTH = 30,
  parameter int N_BALLS = 4,
  parameter logic [WIDTH-1:0] R2_LIMIT = 32'h0400_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             sweep_done,
  output logic [3:0]       rd_idx,
  input  logic [WIDTH-1:0] rd_x,
  input  logic [WIDTH-1:0] rd_y,
  input  logic [WIDTH-1:0] rd_vx,
  input  logic [WIDTH-1:0] rd_vy,
  output logic             wr_en,
  output logic [3:0]       wr_idx,
  output logic [WIDTH-1:0] wr_vx,
  output logic [WIDTH-1:0] wr_vy,
  output logic             calc_start,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] v0_x,
  output logic [WIDTH-1:0] v0_y,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] v1_x,
  output logic [WIDTH-1:0] v1_y,
  input  logic             calc_done,
  input  logic [WIDTH-1:0] new_v0_x,
  input  logic [WIDTH-1:0] new_v0_y,
  input  logic [WIDTH-1:0] new_v1_x,
  input  logic [WIDTH-1:0] new_v1_y,
  output logic [15:0]      collision_count,
  output logic             timeout_err,
  output logic [3:0]       dbg_state
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] RD_I  = 4'd1;
  localparam logic [3:0] RD_J  = 4'd2;
  localparam logic [3:0] CHECK = 4'd3;
  localparam logic [3:0] CALC  = 4'd4;
  localparam logic [3:0] WAIT  = 4'd5;
  localparam logic [3:0] WB_I  = 4'd6;
  localparam logic [3:0] WB_J  = 4'd7;
  localparam logic [3:0] ADV   = 4'd8;

  localparam logic [3:0] LAST_I = 4'(N_BALLS - 2);
  localparam logic [3:0] LAST_J = 4'(N_BALLS - 1);
  localparam int DW = 2 * WIDTH + 4;

  logic [3:0]        state, next_state, i, j;
  logic [WIDTH-1:0]  bi_x, bi_y, bi_vx, bi_vy;
  logic [WIDTH-1:0]  bj_x, bj_y, bj_vx, bj_vy;
  logic [WIDTH-1:0]  r0_vx, r0_vy, r1_vx, r1_vy;
  logic signed [WIDTH:0]  dx, dy;
  logic signed [DW-1:0]   dx_w, dy_w;
  logic [DW-1:0]     dist2, d2;
  logic              collide, last_pair, timeout_hit;

  // Differences carry one guard bit and the squares keep every bit, so the
  // compare sees the exact floor((dx^2+dy^2) >> FRAC_WIDTH).
  always_comb begin
    dx      = $signed({bj_x[WIDTH-1], bj_x}) - $signed({bi_x[WIDTH-1], bi_x});
    dy      = $signed({bj_y[WIDTH-1], bj_y}) - $signed({bi_y[WIDTH-1], bi_y});
    dx_w    = {{(DW-WIDTH-1){dx[WIDTH]}}, dx};
    dy_w    = {{(DW-WIDTH-1){dy[WIDTH]}}, dy};
    dist2   = dx_w * dx_w + dy_w * dy_w;
    d2      = dist2 >> FRAC_WIDTH;
    collide = d2 < {{(DW-WIDTH){1'b0}}, R2_LIMIT};
  end

  assign last_pair = (i == LAST_I) && (j == LAST_J);

  // Handshake: calc_start is a one-cycle request; operands stay stable until
  // WB_J completes; calc_done is accepted only while in WAIT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RD_I;
      RD_I:    next_state = RD_J;
      RD_J:    next_state = CHECK;
      CHECK:   next_state = collide ? CALC : ADV;
      CALC:    next_state = WAIT;
      WAIT:    if (calc_done) next_state = WB_I;
               else if (timeout_hit) next_state = ADV;
      WB_I:    next_state = WB_J;
      WB_J:    next_state = ADV;
      ADV:     next_state = last_pair ? IDLE : RD_I;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      i <= 4'd0;
      j <= 4'd0;
      collision_count <= 16'd0;
      bi_x <= '0; bi_y <= '0; bi_vx <= '0; bi_vy <= '0;
      bj_x <= '0; bj_y <= '0; bj_vx <= '0; bj_vy <= '0;
      r0_vx <= '0; r0_vy <= '0; r1_vx <= '0; r1_vy <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (start) begin
          i <= 4'd0;
          j <= 4'd1;
          collision_count <= 16'd0;
        end
        RD_I: begin
          bi_x <= rd_x; bi_y <= rd_y; bi_vx <= rd_vx; bi_vy <= rd_vy;
        end
        RD_J: begin
          bj_x <= rd_x; bj_y <= rd_y; bj_vx <= rd_vx; bj_vy <= rd_vy;
        end
        WAIT: if (calc_done) begin
          r0_vx <= new_v0_x; r0_vy <= new_v0_y;
          r1_vx <= new_v1_x; r1_vy <= new_v1_y;
        end
        WB_J: if (collision_count != 16'hFFFF) collision_count <= collision_count + 16'd1;
        ADV: if (!last_pair) begin
          if (j == LAST_J) begin
            i <= i + 4'd1;
            j <= i + 4'd2;
          end else begin
            j <= j + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALC_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign timeout_hit = (state == WAIT) && (wait_cnt == 16'd1023);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if (state == CALC) wait_cnt <= 16'd0;
      else if (state == WAIT && !calc_done && !timeout_hit) wait_cnt <= wait_cnt + 16'd1;
      if (!calc_done && timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    busy       = (state != IDLE);
    sweep_done = (state == ADV) && last_pair;
    calc_start = (state == CALC);
    wr_en      = (state == WB_I) || (state == WB_J);
    rd_idx     = 4'd0;
    wr_idx     = 4'd0;
    wr_vx      = '0;
    wr_vy      = '0;
    case (state)
      RD_I: rd_idx = i;
      RD_J: rd_idx = j;
      WB_I: begin wr_idx = i; wr_vx = r0_vx; wr_vy = r0_vy; end
      WB_J: begin wr_idx = j; wr_vx = r1_vx; wr_vy = r1_vy; end
      default: ;
    endcase
  end

  assign x0 = bi_x;  assign y0 = bi_y;  assign v0_x = bi_vx; assign v0_y = bi_vy;
  assign x1 = bj_x;  assign y1 = bj_y;  assign v1_x = bj_vx; assign v1_y = bj_vy;
  assign dbg_state = state;

endmodule
